// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, register offsets and STATUS bit positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [31:0] OFF_TXDATA = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push when full and pop when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with byte FIFO and pollable status
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0] status;
  logic tx_d, pop, fifo_full, fifo_empty, overflow, baud_done;
  logic hit_data, hit_stat, push, ovf_set, ovf_clr, unused;
  assign hit_data = addr == BASE_ADDR + OFF_TXDATA;
  assign hit_stat = addr == BASE_ADDR + OFF_STATUS;
  assign push = mem_write && hit_data;
  assign ovf_set = push && fifo_count == CW'(FIFO_DEPTH);
  assign ovf_clr = mem_write && hit_stat && wdata[3];
  assign busy = state_q != IDLE || !fifo_empty;
  assign baud_done = baud_q == BW'(CLKS_PER_BIT - 1);
  assign unused = ^wdata[31:8];
  always_comb begin
    status = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL] = fifo_full;
    status[ST_BUSY] = busy;
    status[ST_OVF] = overflow;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(wdata[7:0]),
    .pop(pop),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      rdata <= '0;
    end else begin
      overflow <= ovf_set || (overflow && !ovf_clr);
      rdata <= (mem_read && hit_stat) ? status : (mem_read && hit_data) ? '0 : rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx <= tx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    baud_d = baud_done ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    tx_d = tx;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop = 1'b1;
          shift_d = fifo_dout;
          tx_d = 1'b0;
          state_d = START;
        end
      end
      START: if (baud_done) begin
        tx_d = shift_q[0];
        bit_d = '0;
        state_d = DATA;
      end
      DATA: if (baud_done) begin
        if (bit_q == 3'd7) begin
          tx_d = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = shift_q >> 1;
          tx_d = shift_q[1];
          bit_d = bit_q + 1'b1;
        end
      end
      default: if (baud_done) begin
        if (!fifo_empty) begin
          pop = 1'b1;
          shift_d = fifo_dout;
          tx_d = 1'b0;
          state_d = START;
        end else state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench decoding the serial line and checking MMIO status/load behaviour
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, mem_read = 0, mem_write = 0, tx, busy;
  logic [31:0] addr = 0, wdata = 0, rdata;
  int errs = 0, checks = 0, cyc = 0, phase = -1, wr_cyc = 0;
  int starts[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx;
  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) phase = -1;
    else if (phase < 0) begin
      if (tx === 1'b0) begin
        phase = 0;
        starts.push_back(cyc);
      end
    end else begin
      phase++;
      if (phase == 2) check("start_bit", {31'b0, tx}, 0);
      if (phase > 2 && phase < 38 && phase % 4 == 2) rx[phase/4 - 1] = tx;
      if (phase == 38) begin
        check("stop_bit", {31'b0, tx}, 1);
        if (exp_q.size() == 0) check("unexpected_byte", {24'b0, rx}, 32'hxx);
        else check("rx_byte", {24'b0, rx}, {24'b0, exp_q.pop_front()});
      end
      if (phase == 39) phase = -1;
    end
  end
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    mem_write = 1;
    wr_cyc = cyc + 1;
    @(negedge clk);
    mem_write = 0;
  endtask
  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    bus_wr(BASE, {24'b0, b});
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    mem_read = 1;
    @(negedge clk);
    mem_read = 0;
    d = rdata;
  endtask
  task automatic wait_start();
    int n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("start_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 0, 1);
  endtask
  initial begin
    logic [31:0] d;
    int c;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rdata", rdata, 0);
    rst = 0;
    @(negedge clk);
    bus_rd(BASE + 4, d);
    check("status_idle", d, 32'h1);
    bus_rd(BASE + 8, d);
    check("rd_unmapped_holds", d, 32'h1);
    bus_rd(BASE, d);
    check("rd_txdata", d, 0);
    starts.delete();
    send(8'h55);
    wait_start();
    check("start_latency", starts[0] - wr_cyc, 1);
    wait_idle();
    check("frame_len", cyc - starts[0], 40);
    check("sb_drain_1", exp_q.size(), 0);
    starts.delete();
    send(8'hA3);
    send(8'h0F);
    send(8'hC6);
    wait_start();
    wait_idle();
    check("starts_3", starts.size(), 3);
    if (starts.size() == 3) begin
      check("gap_1", starts[1] - starts[0], 40);
      check("gap_2", starts[2] - starts[1], 40);
    end
    check("b2b_busy_len", cyc - starts[0], 120);
    check("sb_drain_3", exp_q.size(), 0);
    send(8'h11);
    wait_start();
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h99);
    bus_wr(BASE, 32'h66);
    bus_wr(BASE, 32'h77);
    bus_rd(BASE + 4, d);
    check("status_ovf", d, 32'hE);
    bus_wr(BASE + 4, 32'h8);
    bus_rd(BASE + 4, d);
    check("status_ovf_clr", d, 32'h6);
    wait_idle();
    check("sb_drain_ovf", exp_q.size(), 0);
    bus_rd(BASE + 4, d);
    check("status_after_ovf", d, 32'h1);
    starts.delete();
    send(8'hA5);
    wait_start();
    repeat (12) @(negedge clk);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    check("midrst_tx", {31'b0, tx}, 1);
    check("midrst_busy", {31'b0, busy}, 0);
    bus_rd(BASE + 4, d);
    check("midrst_status", d, 32'h1);
    send(8'h3C);
    wait_idle();
    check("sb_drain_rst", exp_q.size(), 0);
    starts.delete();
    send(8'h81);
    wait_start();
    c = starts[0];
    send(8'h42);
    send(8'h24);
    send(8'hE7);
    send(8'h18);
    while (cyc < c + 39) @(negedge clk);
    bus_wr(BASE, 32'hBD);
    bus_rd(BASE + 4, d);
    check("status_pop_full", d, 32'hC);
    wait_idle();
    check("sb_drain_popfull", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
